// File: rtl/store_write_buffer.sv
// Post-commit store FIFO that drains committed stores in order to the DataCache write port.
// Define WB_FORWARD_EN to forward full-word data from the youngest matching pending store.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rob_write,
    input  logic [ADDR_W-1:0] rob_addr,
    input  logic [DATA_W-1:0] rob_data,
    input  logic [3:0]        rob_mask,
    output logic              rob_ready,
    output logic              dc_write,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_data,
    output logic [3:0]        dc_mask,
    input  logic              dc_write_done,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hazard,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              empty
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic              dcWrite_q, dcWrite_d;
    logic [ADDR_W-1:0] dcAddr_q, dcAddr_d;
    logic [DATA_W-1:0] dcData_q, dcData_d;
    logic [3:0]        dcMask_q, dcMask_d;

    logic [ADDR_W-1:0] addrMem_q [DEPTH];
    logic [DATA_W-1:0] dataMem_q [DEPTH];
    logic [3:0]        maskMem_q [DEPTH];

    logic              full, push, pop;
    logic [DEPTH-1:0]  wordMatch;
    logic              unusedLdLow;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign rob_ready = !full;
    assign push      = rob_write && !full;

    assign dc_write  = dcWrite_q;
    assign dc_addr   = dcAddr_q;
    assign dc_data   = dcData_q;
    assign dc_mask   = dcMask_q;

    always_comb begin
        state_d   = state_q;
        dcWrite_d = dcWrite_q;
        dcAddr_d  = dcAddr_q;
        dcData_d  = dcData_q;
        dcMask_d  = dcMask_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    dcAddr_d  = addrMem_q[rdPtr_q];
                    dcData_d  = dataMem_q[rdPtr_q];
                    dcMask_d  = maskMem_q[rdPtr_q];
                    dcWrite_d = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (dc_write_done) begin
                    pop       = 1'b1;
                    dcWrite_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Push and pop never target the same slot: that would need the buffer both empty and busy.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        valid_d = valid_q;
        count_d = count_q;
        if (pop) begin
            valid_d[rdPtr_q] = 1'b0;
            rdPtr_d          = rdPtr_q + PTR_ONE;
        end
        if (push) begin
            valid_d[wrPtr_q] = 1'b1;
            wrPtr_d          = wrPtr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            dcWrite_q <= 1'b0;
            dcAddr_q  <= '0;
            dcData_q  <= '0;
            dcMask_q  <= '0;
        end else begin
            state_q   <= state_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            dcWrite_q <= dcWrite_d;
            dcAddr_q  <= dcAddr_d;
            dcData_q  <= dcData_d;
            dcMask_q  <= dcMask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addrMem_q[wrPtr_q] <= rob_addr;
            dataMem_q[wrPtr_q] <= rob_data;
            maskMem_q[wrPtr_q] <= rob_mask;
        end
    end

    // Lookup is word-granular; the byte offset of the load never takes part.
    always_comb begin
        wordMatch = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wordMatch[i] = valid_q[i] && (addrMem_q[i][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
        end
    end

    assign unusedLdLow = ^ld_addr[1:0];

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] selIdx;
    logic             anyMatch;
    logic             fwdFull;

    // Scan oldest to youngest so the last match written is the entry nearest below wr_ptr.
    always_comb begin
        selIdx   = '0;
        anyMatch = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (wordMatch[wrPtr_q - PTR_W'(k)]) begin
                selIdx   = wrPtr_q - PTR_W'(k);
                anyMatch = 1'b1;
            end
        end
        fwdFull   = anyMatch && (maskMem_q[selIdx] == 4'b1111);
        fwd_hit   = fwdFull;
        fwd_data  = fwdFull ? dataMem_q[selIdx] : '0;
        ld_hazard = anyMatch && !fwdFull;
    end
`else
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
    assign ld_hazard = |wordMatch;
`endif

endmodule
